// File: rtl/data_sram_slave_pkg.sv
// Shared definitions for the data SRAM responder: default geometry, counter width
// and the clear/run state encoding.
package data_sram_slave_pkg;

    localparam int          DSRAM_ADDR_WIDTH = 10;
    localparam logic [31:0] DSRAM_BASE_ADDR  = 32'h0000_0000;
    localparam int          DSRAM_CNT_WIDTH  = 16;

    typedef enum logic {
        DSRAM_ST_CLEAR = 1'b0,
        DSRAM_ST_RUN   = 1'b1
    } dsram_state_e;

endpackage

// File: rtl/data_sram_slave_array.sv
// Word-organised synchronous RAM (the dsram array): four byte-write strobes and a
// registered read-first port whose output register resets to zero.
module data_sram_slave_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    input  logic                  rd_load,
    input  logic                  rd_zero,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // The array itself carries no reset; the clear sequence in the parent initialises it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 32'h0;
        end else if (rd_zero) begin
            rdata <= 32'h0;
        end else if (rd_load) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_sram_slave.sv
// Data SRAM responder: post-reset clear FSM, address decode, sticky range error and
// optional saturating access counters (enabled by DATA_SRAM_PERF_CNT_EN).
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int          ADDR_WIDTH = DSRAM_ADDR_WIDTH,
    parameter logic [31:0] BASE_ADDR  = DSRAM_BASE_ADDR,
    parameter int          CNT_WIDTH  = DSRAM_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_wen,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic                 data_sram_ready,
    output logic                 data_sram_err,
    output logic [CNT_WIDTH-1:0] ld_cnt,
    output logic [CNT_WIDTH-1:0] st_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    dsram_state_e          state;
    dsram_state_e          next_state;
    logic [ADDR_WIDTH-1:0] clr_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wdata;
    logic                  rd_load;
    logic                  rd_zero;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^data_sram_addr[1:0];

    assign word_idx        = data_sram_addr[ADDR_WIDTH+1:2];
    assign in_range        = (data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign data_sram_ready = (state == DSRAM_ST_RUN);
    assign accept          = data_sram_en && data_sram_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DSRAM_ST_CLEAR;
            clr_idx <= '0;
        end else begin
            state <= next_state;
            if (state == DSRAM_ST_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
        end
    end

    // While clearing, the array port belongs to the clear sequence and requests are ignored.
    always_comb begin
        next_state = state;
        mem_we     = 4'h0;
        mem_idx    = word_idx;
        mem_wdata  = data_sram_wdata;
        rd_load    = 1'b0;
        rd_zero    = 1'b0;
        case (state)
            DSRAM_ST_CLEAR: begin
                mem_we    = 4'hf;
                mem_idx   = clr_idx;
                mem_wdata = 32'h0;
                if (clr_idx == '1) begin
                    next_state = DSRAM_ST_RUN;
                end
            end
            DSRAM_ST_RUN: begin
                if (data_sram_en) begin
                    if (in_range) begin
                        rd_load = 1'b1;
                        mem_we  = data_sram_wen;
                    end else begin
                        rd_zero = 1'b1;
                    end
                end
            end
            default: next_state = DSRAM_ST_CLEAR;
        endcase
    end

    data_sram_slave_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .idx     (mem_idx),
        .wdata   (mem_wdata),
        .rd_load (rd_load),
        .rd_zero (rd_zero),
        .rdata   (data_sram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sram_err <= 1'b0;
        end else if (accept && !in_range) begin
            data_sram_err <= 1'b1;
        end
    end

`ifdef DATA_SRAM_PERF_CNT_EN
    logic is_load;
    logic is_store;
    logic is_bad;

    assign is_load  = accept && in_range && (data_sram_wen == 4'h0);
    assign is_store = accept && in_range && (data_sram_wen != 4'h0);
    assign is_bad   = accept && !in_range;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt  <= '0;
            st_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (is_load && (ld_cnt != '1)) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (is_store && (st_cnt != '1)) begin
                st_cnt <= st_cnt + 1'b1;
            end
            if (is_bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    assign ld_cnt  = '0;
    assign st_cnt  = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_data_sram_slave.sv
// Self-checking bench for data_sram_slave: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_data_sram_slave;

    localparam int CW    = 4;
    localparam int DEPTH = 1024;

    logic          clk;
    logic          reset;
    logic          data_sram_en;
    logic [3:0]    data_sram_wen;
    logic [31:0]   data_sram_addr;
    logic [31:0]   data_sram_wdata;
    logic [31:0]   data_sram_rdata;
    logic          data_sram_ready;
    logic          data_sram_err;
    logic [CW-1:0] ld_cnt;
    logic [CW-1:0] st_cnt;
    logic [CW-1:0] err_cnt;

    int tests_run;
    int tests_failed;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        model_ready;
    int          n_ld;
    int          n_st;
    int          n_bad;

    data_sram_slave #(
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .data_sram_ready (data_sram_ready),
        .data_sram_err   (data_sram_err),
        .ld_cnt          (ld_cnt),
        .st_cnt          (st_cnt),
        .err_cnt         (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count(input int n);
`ifdef DATA_SRAM_PERF_CNT_EN
        return (n > 15) ? 32'd15 : 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic check_all(input string tag);
        check_output({tag, ".rdata"}, data_sram_rdata, exp_rdata);
        check_output({tag, ".ready"}, 32'(data_sram_ready), 32'(model_ready));
        check_output({tag, ".err"}, 32'(data_sram_err), 32'(exp_err));
        check_output({tag, ".ld_cnt"}, 32'(ld_cnt), exp_count(n_ld));
        check_output({tag, ".st_cnt"}, 32'(st_cnt), exp_count(n_st));
        check_output({tag, ".err_cnt"}, 32'(err_cnt), exp_count(n_bad));
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        exp_rdata   = 32'h0;
        exp_err     = 1'b0;
        model_ready = 1'b0;
        n_ld        = 0;
        n_st        = 0;
        n_bad       = 0;
    endtask

    // One request cycle: update the model from the request, clock it, then compare.
    task automatic apply_stimulus(input string tag, input logic en, input logic [3:0] wen,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] word;
        int          idx;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        if (model_ready && en) begin
            if (addr < 32'h0000_1000) begin
                idx       = int'(addr >> 2);
                word      = model_mem[idx];
                exp_rdata = word;
                if (wen == 4'h0) begin
                    n_ld++;
                end else begin
                    n_st++;
                    for (int b = 0; b < 4; b++) begin
                        if (wen[b]) word[8*b +: 8] = wdata[8*b +: 8];
                    end
                    model_mem[idx] = word;
                end
            end else begin
                exp_rdata = 32'h0;
                exp_err   = 1'b1;
                n_bad++;
            end
        end
        @(posedge clk);
        #1;
        data_sram_en = 1'b0;
        check_all(tag);
    endtask

    // Hammer the port with ignored requests while the clear runs, then count its length.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!data_sram_ready && n < 2000) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = 4'($urandom);
            data_sram_addr  = $urandom_range(0, 32'h0fff);
            data_sram_wdata = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        data_sram_en = 1'b0;
        check_output({tag, ".clear_cycles"}, 32'(n), 32'd1024);
        model_ready = 1'b1;
        check_all({tag, ".after_clear"});
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        reset_model();

        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("ready_low_after_release", 32'(data_sram_ready), 32'd0);
        wait_ready("clear1");

        apply_stimulus("read_cleared_0x0", 1'b1, 4'h0, 32'h0000_0000, 32'h0);
        apply_stimulus("read_cleared_0xffc", 1'b1, 4'h0, 32'h0000_0ffc, 32'h0);
        apply_stimulus("write_full_0x40", 1'b1, 4'hf, 32'h0000_0040, 32'h1234_5678);
        apply_stimulus("read_0x40", 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        check_output("read_0x40_const", data_sram_rdata, 32'h1234_5678);
        apply_stimulus("write_partial_0x40", 1'b1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD);
        apply_stimulus("read_partial_0x40", 1'b1, 4'h0, 32'h0000_0043, 32'h0);
        check_output("read_partial_const", data_sram_rdata, 32'h12BB_56DD);
        apply_stimulus("idle_hold", 1'b0, 4'hf, 32'h0000_0040, 32'hFFFF_FFFF);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus("load_burst", 1'b1, 4'h0, 32'($urandom_range(0, 63)) << 2, 32'h0);
        end
`ifdef DATA_SRAM_PERF_CNT_EN
        check_output("ld_cnt_saturated", 32'(ld_cnt), 32'hf);
`else
        check_output("ld_cnt_tied_zero", 32'(ld_cnt), 32'h0);
`endif

        apply_stimulus("oor_read_0x1000", 1'b1, 4'h0, 32'h0000_1000, 32'h0);
        apply_stimulus("oor_write", 1'b1, 4'hf, 32'h0000_1040, 32'hDEAD_BEEF);
        apply_stimulus("read_after_oor", 1'b1, 4'h0, 32'h0000_0040, 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom | 32'h0000_1000;
            end else begin
                a = 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 32'h0fff);
            end
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            apply_stimulus("random", ($urandom_range(0, 3) != 0), w, a, $urandom);
        end

        reset = 1'b1;
        #1;
        reset_model();
        check_all("mid_run_reset");
        @(negedge clk);
        reset = 1'b0;
        wait_ready("clear2");
        apply_stimulus("read_0x40_after_reset", 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        apply_stimulus("write_after_reset", 1'b1, 4'b1000, 32'h0000_0080, 32'h5500_0000);
        apply_stimulus("read_after_reset", 1'b1, 4'h0, 32'h0000_0080, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
